// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, FSM states and request helpers for mem_access_unit
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_DATA,
      ST_WR,
      ST_RESP
   } state_t;

   // Size 2'b11 is handled exactly like a word.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) || (is_word(size) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_data_align.sv
// rtl/mem_data_align.sv - sub-word store merge and load sign/zero extension
module mem_data_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_ld_data,
   output logic [DATA_W-1:0] o_st_data
);

   logic w_sext_b;
   logic w_sext_h;

   assign w_sext_b = ~i_unsigned & i_rdata[7];
   assign w_sext_h = ~i_unsigned & i_rdata[15];

   always_comb begin
      o_ld_data = i_rdata;
      o_st_data = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_ld_data = {{(DATA_W-8){w_sext_b}}, i_rdata[7:0]};
            o_st_data = {i_rdata[DATA_W-1:8], i_wdata[7:0]};
         end
         SZ_HALF: begin
            o_ld_data = {{(DATA_W-16){w_sext_h}}, i_rdata[15:0]};
            o_st_data = {i_rdata[DATA_W-1:16], i_wdata[15:0]};
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with RMW sub-word stores
// Optional misalign trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_memwr_o,
   output logic              mem_memrd_o,
   input  logic [DATA_W-1:0] mem_rddata_i
);

   state_t            r_state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] w_ld_data;
   logic [DATA_W-1:0] w_st_data;

   mem_data_align #(.DATA_W(DATA_W)) u_align (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_rdata    (mem_rddata_i),
      .i_wdata    (r_wdata),
      .o_ld_data  (w_ld_data),
      .o_st_data  (w_st_data)
   );

   assign req_ready_o = (r_state == ST_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_err;
   assign resp_err_o = r_err;
`else
   assign resp_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_wdata      <= '0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_memwr_o  <= 1'b0;
         mem_memrd_o  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         r_err        <= 1'b0;
`endif
      end else begin
         resp_valid_o <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  r_we         <= req_we_i;
                  r_size       <= req_size_i;
                  r_unsigned   <= req_unsigned_i;
                  r_wdata      <= req_wdata_i;
                  mem_addr_o   <= req_addr_i;
                  resp_rdata_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                  r_err        <= 1'b0;
                  if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
                     r_err        <= 1'b1;
                     resp_valid_o <= 1'b1;
                     r_state      <= ST_RESP;
                  end else
`endif
                  if (req_we_i && is_word(req_size_i)) begin
                     mem_wdata_o <= req_wdata_i;
                     mem_memwr_o <= 1'b1;
                     r_state     <= ST_WR;
                  end else begin
                     mem_memrd_o <= 1'b1;
                     r_state     <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               mem_memrd_o <= 1'b0;
               r_state     <= ST_DATA;
            end
            // Read word arrives this cycle: finish a load or build the RMW word.
            ST_DATA: begin
               if (r_we) begin
                  mem_wdata_o <= w_st_data;
                  mem_memwr_o <= 1'b1;
                  r_state     <= ST_WR;
               end else begin
                  resp_rdata_o <= w_ld_data;
                  resp_valid_o <= 1'b1;
                  r_state      <= ST_RESP;
               end
            end
            ST_WR: begin
               mem_memwr_o  <= 1'b0;
               resp_valid_o <= 1'b1;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-level memory model
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'b00;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_memwr_o;
   logic        mem_memrd_o;
   logic [31:0] mem_rddata_i = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem     [64];
   logic [7:0] ref_mem [64];

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_memwr_o    (mem_memwr_o),
      .mem_memrd_o    (mem_memrd_o),
      .mem_rddata_i   (mem_rddata_i)
   );

   always #5 clk_i = ~clk_i;

   // 64-byte memory: 4-byte little-endian read/write, registered read data.
   always @(posedge clk_i) begin
      if (rst_i && (n_tests == 0)) begin
         for (int k = 0; k < 64; k++) mem[k] <= ref_mem[k];
      end else begin
         if (mem_memrd_o)
            mem_rddata_i <= {mem[mem_addr_o[5:0] + 6'd3], mem[mem_addr_o[5:0] + 6'd2],
                             mem[mem_addr_o[5:0] + 6'd1], mem[mem_addr_o[5:0]]};
         if (mem_memwr_o) begin
            mem[mem_addr_o[5:0]]        <= mem_wdata_o[7:0];
            mem[mem_addr_o[5:0] + 6'd1] <= mem_wdata_o[15:8];
            mem[mem_addr_o[5:0] + 6'd2] <= mem_wdata_o[23:16];
            mem[mem_addr_o[5:0] + 6'd3] <= mem_wdata_o[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int bidx(input logic [31:0] addr, input int k);
      return (int'(addr % 64) + k) % 64;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] addr);
      logic [31:0] w = 0;
      for (int k = 3; k >= 0; k--) w = w * 256 + 32'(ref_mem[bidx(addr, k)]);
      return w;
   endfunction

   function automatic logic [31:0] tb_word(input logic [31:0] addr);
      logic [31:0] w = 0;
      for (int k = 3; k >= 0; k--) w = w * 256 + 32'(mem[bidx(addr, k)]);
      return w;
   endfunction

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
      longint w   = longint'(ref_word(addr));
      longint lim = longint'(1) << (8 * nbytes(size));
      longint v   = w % lim;
      if (!uns && nbytes(size) < 4 && v >= lim / 2) v = v - lim;
      return 32'(v);
   endfunction

   function automatic void ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d = wdata;
      for (int k = 0; k < nbytes(size); k++) begin
         ref_mem[bidx(addr, k)] = 8'(d % 256);
         d = d / 256;
      end
   endfunction

   function automatic logic ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
      return (nbytes(size) > 1) && (addr % nbytes(size) != 0);
`else
      return (size == 2'd3) && (addr === 32'hx);
`endif
   endfunction

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int rd_cyc = 0, wr_cyc = 0, resp_cyc = 0, n_rd = 0, n_wr = 0, both = 0;
      int exp_rd, exp_wr, exp_resp;
      logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, rdata = '0;
      logic [31:0] exp_rdata = '0;
      logic err = 1'b0;
      logic mis;
      @(negedge clk_i);
      check("ready_idle", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
      req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (mem_memrd_o) begin n_rd++; if (rd_cyc == 0) begin rd_cyc = c; rd_addr = mem_addr_o; end end
         if (mem_memwr_o) begin n_wr++; if (wr_cyc == 0) begin wr_cyc = c; wr_addr = mem_addr_o; wr_data = mem_wdata_o; end end
         if (mem_memrd_o && mem_memwr_o) both++;
         if (resp_valid_o) begin resp_cyc = c; rdata = resp_rdata_o; err = resp_err_o; break; end
         @(negedge clk_i);
      end
      mis = ref_misaligned(size, addr);
      if (mis) begin
         exp_rd = 0; exp_wr = 0; exp_resp = 1;
      end else if (we && nbytes(size) == 4) begin
         exp_rd = 0; exp_wr = 1; exp_resp = 2; ref_store(addr, size, wdata);
      end else if (we) begin
         exp_rd = 1; exp_wr = 3; exp_resp = 4; ref_store(addr, size, wdata);
      end else begin
         exp_rd = 1; exp_wr = 0; exp_resp = 3; exp_rdata = ref_load(addr, size, uns);
      end
      check("resp_cycle", 32'(resp_cyc), 32'(exp_resp));
      check("rd_cycle", 32'(rd_cyc), 32'(exp_rd));
      check("wr_cycle", 32'(wr_cyc), 32'(exp_wr));
      check("rd_count", 32'(n_rd), 32'(exp_rd != 0));
      check("wr_count", 32'(n_wr), 32'(exp_wr != 0));
      check("rd_wr_overlap", 32'(both), 32'd0);
      check("resp_rdata", rdata, exp_rdata);
      check("resp_err", 32'(err), 32'(mis));
      if (exp_rd != 0) check("rd_addr", rd_addr, addr);
      if (exp_wr != 0) begin
         check("wr_addr", wr_addr, addr);
         check("wr_data", wr_data, ref_word(addr));
      end
      check("mem_word", tb_word(addr), ref_word(addr));
   endtask

   initial begin
      int r1 = 0, r2 = 0, n_resp = 0, n_ready = 0, both = 0;
      logic [31:0] rdata2 = '0;
      for (int k = 0; k < 64; k++) ref_mem[k] = 8'($urandom);

      repeat (2) @(negedge clk_i);
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      check("rst_memwr", 32'(mem_memwr_o), 32'd0);
      check("rst_memrd", 32'(mem_memrd_o), 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_rdata", resp_rdata_o, 32'd0);
      rst_i = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      do_req(1'b1, 2'd0, 1'b0, 32'h08, 32'h000000AA);
      do_req(1'b0, 2'd0, 1'b0, 32'h08, 32'h0);
      do_req(1'b0, 2'd0, 1'b1, 32'h08, 32'h0);
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12348001);
      do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
      do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hCAFE7F55);
      do_req(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0);

      // Two loads with req_valid_i held high throughout.
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
      req_unsigned_i = 1'b0; req_addr_i = 32'h10;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_i);
         if (req_ready_o) n_ready++;
         if (mem_memrd_o && mem_memwr_o) both++;
         if (resp_valid_o) begin
            n_resp++;
            if (n_resp == 1) r1 = c;
            if (n_resp == 2) begin r2 = c; rdata2 = resp_rdata_o; req_valid_i = 1'b0; break; end
         end
      end
      req_valid_i = 1'b0;
      check("b2b_resp1", 32'(r1), 32'd3);
      check("b2b_resp2", 32'(r2), 32'd7);
      check("b2b_ready_cycles", 32'(n_ready), 32'd1);
      check("b2b_overlap", 32'(both), 32'd0);
      check("b2b_rdata", rdata2, ref_load(32'h10, 2'd2, 1'b0));

      // Reset pulse while the word-store write strobe is up.
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h18;
      req_wdata_i = ~ref_word(32'h18);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("wr_before_rst", 32'(mem_memwr_o), 32'd1);
      #1 rst_i = 1'b1;
      #1;
      check("rst_wr_memwr", 32'(mem_memwr_o), 32'd0);
      check("rst_wr_ready", 32'(req_ready_o), 32'd1);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_wr_mem", tb_word(32'h18), ref_word(32'h18));
      check("rst_wr_idle", 32'(req_ready_o), 32'd1);

      for (int i = 0; i < 40; i++)
         do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
